register_file_sb: RTL

REGISTER_FILE_SB -- requirements
Module: register_file_sb

---
 rtl/register_file_sb.sv | 118 +++++++++++
 1 files changed

// File: rtl/register_file_sb.sv
// Register file with per-register pending scoreboard and power-up self-initialisation.
// Optional same-cycle write-back forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_REGS = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              ready
);

  typedef enum logic {StInit, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];

  logic                run;
  logic [ADDR_W-1:0]   src_a     [2];
  logic [DATA_W-1:0]   rd_data   [2];
  logic                rd_hazard [2];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  assign run = (state_q == StRun);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StInit) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
        state_d = StRun;
        cnt_d   = '0;
      end
    end
  end

  // Issue is applied after write-back so a same-address pair leaves the bit set.
  always_comb begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      regs_d[i]    = regs_q[i];
      pending_d[i] = pending_q[i];
      if (!run && cnt_q == ADDR_W'(i)) begin
        regs_d[i] = DATA_W'(i);
      end
      if (run && wb_en && wb_dest == ADDR_W'(i)) begin
        regs_d[i]    = wb_data;
        pending_d[i] = 1'b0;
      end
      if (run && issue_en && issue_dest == ADDR_W'(i)) begin
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StInit;
      cnt_q     <= '0;
      pending_q <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign src_a[0] = src1;
  assign src_a[1] = src2;

  // Both ports share one decode so equal addresses always yield equal results.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p]   = '0;
      rd_hazard[p] = 1'b0;
      if (run && in_range(src_a[p])) begin
        rd_data[p]   = regs_q[src_a[p]];
        rd_hazard[p] = pending_q[src_a[p]];
`ifdef REGFILE_BYPASS_EN
        if (wb_en && wb_dest == src_a[p]) begin
          rd_data[p]   = wb_data;
          rd_hazard[p] = issue_en && (issue_dest == src_a[p]);
        end
`endif
      end
    end
  end

  assign reg1    = rd_data[0];
  assign reg2    = rd_data[1];
  assign hazard1 = rd_hazard[0];
  assign hazard2 = rd_hazard[1];
  assign ready   = run;

endmodule
